// File: rtl/uart_pkg.sv
// Shared constants, status codes and FSM states for the UART command responder.
// Imported by the responder top and its byte sender.
package uart_pkg;

    localparam logic [7:0] SOF_CMD = 8'hA5;
    localparam logic [7:0] SOF_RSP = 8'h5A;
    localparam logic [7:0] CMD_WR  = 8'h57;
    localparam logic [7:0] CMD_RD  = 8'h52;

    localparam logic [7:0] ST_OK       = 8'h00;
    localparam logic [7:0] ST_BAD_CHK  = 8'h01;
    localparam logic [7:0] ST_BAD_CMD  = 8'h02;
    localparam logic [7:0] ST_BAD_ADDR = 8'h03;

    typedef enum logic [3:0] {
        IDLE,
        GET_CMD,
        GET_ADDR,
        GET_DATA,
        GET_CHK,
        EXEC,
        TX_PULSE,
        TX_WAIT_HI,
        TX_WAIT_LO
    } state_t;

    // Response frame byte for a given index: SOF, STATUS, RDATA, RCHK.
    function automatic logic [7:0] rsp_byte(
        input logic [1:0] idx,
        input logic [7:0] status,
        input logic [7:0] rdata
    );
        logic [7:0] b;
        case (idx)
            2'd0:    b = SOF_RSP;
            2'd1:    b = status;
            2'd2:    b = rdata;
            default: b = status ^ rdata;
        endcase
        return b;
    endfunction

endpackage

// File: rtl/uart_cmd_responder_sender.sv
// Single-byte transmit handshake: pulse tx_start while the
// transmitter is idle, then wait for tx_busy to rise and fall.
module uart_byte_sender
    import uart_pkg::*;
(
    input  logic       clk,
    input  logic       rst,
    input  logic       send,
    input  logic [7:0] byte_in,
    input  logic       tx_busy,
    output logic [7:0] tx_data,
    output logic       tx_start,
    output logic       done
);

    state_t state;
    state_t state_nxt;

    // Handshake state register.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) state <= IDLE;
        else     state <= state_nxt;
    end

    // Latch the byte on send; it stays put until the next send.
    always_ff @(posedge clk or posedge rst) begin
        if (rst)       tx_data <= 8'h00;
        else if (send) tx_data <= byte_in;
    end

    // Next state, start pulse and done pulse.
    always_comb begin
        state_nxt = state;
        tx_start  = 1'b0;
        done      = 1'b0;
        unique case (state)
            IDLE: begin
                if (send) state_nxt = TX_PULSE;
            end
            TX_PULSE: begin
                if (!tx_busy) begin
                    tx_start  = 1'b1;
                    state_nxt = TX_WAIT_HI;
                end
            end
            TX_WAIT_HI: begin
                if (tx_busy) state_nxt = TX_WAIT_LO;
            end
            TX_WAIT_LO: begin
                if (!tx_busy) begin
                    done      = 1'b1;
                    state_nxt = send ? TX_PULSE : IDLE;
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

endmodule

// File: rtl/uart_cmd_responder.sv
// Parses A5-framed register commands from the UART receiver, performs
// the register access and answers with a 4-byte 5A-framed response.
module uart_cmd_responder
    import uart_pkg::*;
#(
    parameter int NREGS          = 16,
    parameter int TIMEOUT_CYCLES = 100000
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [7:0] rx_data,
    input  logic       rx_ready,
    input  logic       tx_busy,
    output logic [7:0] tx_data,
    output logic       tx_start,
    output logic [7:0] reg_addr,
    output logic [7:0] reg_wdata,
    output logic       reg_we,
    input  logic [7:0] reg_rdata,
    output logic       busy
);

    localparam int CW = $clog2(TIMEOUT_CYCLES + 1);

    state_t        state;
    state_t        state_nxt;
    logic [7:0]    cmd_r;
    logic [7:0]    chk_r;
    logic [7:0]    status_r;
    logic [7:0]    rdata_r;
    logic [1:0]    idx;
    logic [CW-1:0] cnt;
    logic          in_get;
    logic          timeout;
    logic          is_wr;
    logic [7:0]    calc_chk;
    logic [7:0]    status_c;
    logic [7:0]    rdata_c;
    logic          send;
    logic [7:0]    send_byte;
    logic          done;

    assign busy    = (state != IDLE);
    assign in_get  = (state == GET_CMD) || (state == GET_ADDR) ||
                     (state == GET_DATA) || (state == GET_CHK);
    assign timeout = in_get && (cnt == CW'(TIMEOUT_CYCLES - 1));
    assign is_wr   = (cmd_r == CMD_WR);

    // Status and response data, consumed in EXEC.
    always_comb begin
        calc_chk = cmd_r ^ reg_addr ^ (is_wr ? reg_wdata : 8'h00);
        if (calc_chk != chk_r)
            status_c = ST_BAD_CHK;
        else if (!is_wr && cmd_r != CMD_RD)
            status_c = ST_BAD_CMD;
        else if (int'(reg_addr) >= NREGS)
            status_c = ST_BAD_ADDR;
        else
            status_c = ST_OK;
        if (status_c != ST_OK) rdata_c = 8'h00;
        else if (is_wr)        rdata_c = reg_wdata;
        else                   rdata_c = reg_rdata;
    end

    // Main FSM state register.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) state <= IDLE;
        else     state <= state_nxt;
    end

    // Inter-byte timeout counter, live only while collecting a frame.
    always_ff @(posedge clk or posedge rst) begin
        if (rst)                   cnt <= '0;
        else if (rx_ready || !in_get) cnt <= '0;
        else                       cnt <= cnt + CW'(1);
    end

    // Frame fields, latched result and response byte index.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cmd_r     <= 8'h00;
            reg_addr  <= 8'h00;
            reg_wdata <= 8'h00;
            chk_r     <= 8'h00;
            status_r  <= 8'h00;
            rdata_r   <= 8'h00;
            idx       <= 2'd0;
        end else begin
            if (rx_ready) begin
                case (state)
                    GET_CMD:  cmd_r     <= rx_data;
                    GET_ADDR: reg_addr  <= rx_data;
                    GET_DATA: reg_wdata <= rx_data;
                    GET_CHK:  chk_r     <= rx_data;
                    default:  ;
                endcase
            end
            if (state == EXEC) begin
                status_r <= status_c;
                rdata_r  <= rdata_c;
                idx      <= 2'd0;
            end else if (done) begin
                idx <= idx + 2'd1;
            end
        end
    end

    // Next state, write strobe and byte hand-off to the sender.
    // While a response is out the FSM parks in TX_PULSE; the sender
    // walks the per-byte pulse / wait-high / wait-low handshake.
    always_comb begin
        state_nxt = state;
        send      = 1'b0;
        send_byte = SOF_RSP;
        reg_we    = 1'b0;
        unique case (state)
            IDLE: begin
                if (rx_ready && rx_data == SOF_CMD) state_nxt = GET_CMD;
            end
            GET_CMD: begin
                if (rx_ready)     state_nxt = GET_ADDR;
                else if (timeout) state_nxt = IDLE;
            end
            GET_ADDR: begin
                if (rx_ready)     state_nxt = is_wr ? GET_DATA : GET_CHK;
                else if (timeout) state_nxt = IDLE;
            end
            GET_DATA: begin
                if (rx_ready)     state_nxt = GET_CHK;
                else if (timeout) state_nxt = IDLE;
            end
            GET_CHK: begin
                if (rx_ready)     state_nxt = EXEC;
                else if (timeout) state_nxt = IDLE;
            end
            EXEC: begin
                reg_we    = is_wr && (status_c == ST_OK);
                send      = 1'b1;
                send_byte = SOF_RSP;
                state_nxt = TX_PULSE;
            end
            TX_PULSE: begin
                if (done) begin
                    if (idx == 2'd3) begin
                        state_nxt = IDLE;
                    end else begin
                        send      = 1'b1;
                        send_byte = rsp_byte(idx + 2'd1, status_r, rdata_r);
                    end
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

    uart_byte_sender u_sender (
        .clk      (clk),
        .rst      (rst),
        .send     (send),
        .byte_in  (send_byte),
        .tx_busy  (tx_busy),
        .tx_data  (tx_data),
        .tx_start (tx_start),
        .done     (done)
    );

endmodule

// File: tb/tb_uart_cmd_responder.sv
// Directed bench for uart_cmd_responder: command vector table plus
// timeout, backpressure and mid-response reset sequences.
module tb_uart_cmd_responder;

    localparam int NREGS = 16;
    localparam int TMO   = 200;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic [7:0] rx_data = 8'h00;
    logic       rx_ready = 1'b0;
    logic       tx_busy = 1'b0;
    logic [7:0] tx_data;
    logic       tx_start;
    logic [7:0] reg_addr;
    logic [7:0] reg_wdata;
    logic       reg_we;
    logic [7:0] reg_rdata;
    logic       busy;

    logic [7:0] mem [16] = '{default: 8'h11};
    int         total = 0;
    int         bad = 0;
    int         cyc = 0;
    int         last_rx_cyc = 0;
    int         we_n = 0;
    logic [7:0] we_addr = 8'h00;
    logic [7:0] we_data = 8'h00;
    int         stab_err = 0;
    int         busy_len = 3;
    int         busy_cnt = 0;
    logic [7:0] hold = 8'h00;
    logic [7:0] rsp_q [$];
    int         tx_cyc_q [$];

    typedef struct {
        logic [39:0] frame;
        int          len;
        logic [31:0] rsp;
        int          we;
        logic [7:0]  wa;
        logic [7:0]  wd;
        string       name;
    } vec_t;

    vec_t vt [5];

    assign reg_rdata = (reg_addr < 8'd16) ? mem[reg_addr[3:0]] : 8'hEE;

    uart_cmd_responder #(
        .NREGS          (NREGS),
        .TIMEOUT_CYCLES (TMO)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .rx_data   (rx_data),
        .rx_ready  (rx_ready),
        .tx_busy   (tx_busy),
        .tx_data   (tx_data),
        .tx_start  (tx_start),
        .reg_addr  (reg_addr),
        .reg_wdata (reg_wdata),
        .reg_we    (reg_we),
        .reg_rdata (reg_rdata),
        .busy      (busy)
    );

    always #5 clk = ~clk;

    // Register bank, transmitter model and event recorder.
    always @(posedge clk) begin
        cyc <= cyc + 1;
        if (rx_ready) last_rx_cyc <= cyc;
        if (reg_we) begin
            we_n    <= we_n + 1;
            we_addr <= reg_addr;
            we_data <= reg_wdata;
            if (reg_addr < 8'd16) mem[reg_addr[3:0]] <= reg_wdata;
        end
        if (tx_start) begin
            if (tx_busy) stab_err <= stab_err + 1;
            rsp_q.push_back(tx_data);
            tx_cyc_q.push_back(cyc);
            hold     <= tx_data;
            busy_cnt <= busy_len;
            tx_busy  <= 1'b1;
        end else if (tx_busy) begin
            if (tx_data !== hold) stab_err <= stab_err + 1;
            if (busy_cnt <= 1) tx_busy <= 1'b0;
            else               busy_cnt <= busy_cnt - 1;
        end
    end

    task automatic check(input string name, input int act, input int exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic send_byte(input logic [7:0] b);
        rx_data  = b;
        rx_ready = 1'b1;
        @(negedge clk);
        rx_ready = 1'b0;
        @(negedge clk);
    endtask

    task automatic expect_rsp(input int base, input logic [31:0] exp,
                              input string name);
        int n;
        int act;
        n = 0;
        while (rsp_q.size() < base + 4 && n < 2000) begin
            @(negedge clk);
            n++;
        end
        check({name, " rsp_count"}, rsp_q.size() - base, 4);
        n = 0;
        while (busy && n < 100) begin
            @(negedge clk);
            n++;
        end
        check({name, " idle_after"}, int'(busy), 0);
        for (int i = 0; i < 4; i++) begin
            act = (rsp_q.size() > base + i) ? int'(rsp_q[base + i]) : -1;
            check($sformatf("%s byte%0d", name, i), act,
                  int'(exp[31 - 8*i -: 8]));
        end
    endtask

    task automatic apply_vec(input vec_t v);
        int base;
        int wbase;
        int chk_cyc;
        base  = rsp_q.size();
        wbase = we_n;
        for (int i = 0; i < v.len; i++) send_byte(v.frame[39 - 8*i -: 8]);
        chk_cyc = last_rx_cyc;
        expect_rsp(base, v.rsp, v.name);
        if (tx_cyc_q.size() > base)
            check({v.name, " latency"}, tx_cyc_q[base] - chk_cyc, 2);
        check({v.name, " we_count"}, we_n - wbase, v.we);
        if (v.we > 0) begin
            check({v.name, " we_addr"}, int'(we_addr), int'(v.wa));
            check({v.name, " we_data"}, int'(we_data), int'(v.wd));
        end
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        int base;
        int n;
        vec_t v;

        vt[0] = '{40'hA557033C68, 5, 32'h5A003C3C, 1, 8'h03, 8'h3C, "write"};
        vt[1] = '{40'hA552035100, 4, 32'h5A003C3C, 0, 8'h00, 8'h00, "read"};
        vt[2] = '{40'hA552030000, 4, 32'h5A010001, 0, 8'h00, 8'h00, "bad_chk"};
        vt[3] = '{40'hA533033000, 4, 32'h5A020002, 0, 8'h00, 8'h00, "bad_cmd"};
        vt[4] = '{40'hA557201166, 5, 32'h5A030003, 0, 8'h00, 8'h00, "bad_addr"};

        repeat (3) @(negedge clk);
        check("reset_outputs",
              int'({tx_data, tx_start, reg_addr, reg_wdata, reg_we, busy}), 0);
        rst = 1'b0;
        repeat (2) @(negedge clk);

        for (int i = 0; i < 5; i++) apply_vec(vt[i]);

        // Garbage bytes, then a frame that stalls into the timeout.
        base = rsp_q.size();
        n    = we_n;
        send_byte(8'h00);
        send_byte(8'hFF);
        check("garbage_idle", int'(busy), 0);
        send_byte(8'hA5);
        send_byte(8'h52);
        repeat (TMO - 2) @(negedge clk);
        check("tmo_not_yet", int'(busy), 1);
        @(negedge clk);
        check("tmo_expired", int'(busy), 0);
        check("tmo_no_tx", rsp_q.size() - base, 0);
        check("tmo_no_we", we_n - n, 0);
        apply_vec(vt[1]);

        // Byte arriving on the expiry cycle keeps the frame alive.
        base = rsp_q.size();
        send_byte(8'hA5);
        send_byte(8'h52);
        repeat (TMO - 2) @(negedge clk);
        send_byte(8'h03);
        send_byte(8'h51);
        expect_rsp(base, 32'h5A003C3C, "tmo_edge");

        // Slow transmitter with a whole frame injected mid-response.
        busy_len = 50;
        base     = rsp_q.size();
        send_byte(8'hA5);
        send_byte(8'h52);
        send_byte(8'h03);
        send_byte(8'h51);
        repeat (25) @(negedge clk);
        send_byte(8'hA5);
        repeat (25) @(negedge clk);
        send_byte(8'h52);
        repeat (25) @(negedge clk);
        send_byte(8'h03);
        repeat (25) @(negedge clk);
        send_byte(8'h51);
        expect_rsp(base, 32'h5A003C3C, "bp");
        repeat (300) @(negedge clk);
        check("bp_no_extra_tx", rsp_q.size() - base, 4);
        check("bp_tx_stable", stab_err, 0);
        busy_len = 10;

        // Reset after the second response byte is launched.
        base = rsp_q.size();
        send_byte(8'hA5);
        send_byte(8'h52);
        send_byte(8'h03);
        send_byte(8'h51);
        n = 0;
        while (rsp_q.size() < base + 2 && n < 1000) begin
            @(negedge clk);
            n++;
        end
        check("rst_two_sent", rsp_q.size() - base, 2);
        check("rst_busy_before", int'(busy), 1);
        rst = 1'b1;
        #1;
        check("rst_immediate", int'({tx_start, busy, reg_we}), 0);
        repeat (3) @(negedge clk);
        rst = 1'b0;
        repeat (100) @(negedge clk);
        check("rst_no_more_tx", rsp_q.size() - base, 2);
        v = '{40'hA55705AAF8, 5, 32'h5A00AAAA, 1, 8'h05, 8'hAA, "post_rst_wr"};
        apply_vec(v);
        v = '{40'hA552055700, 4, 32'h5A00AAAA, 0, 8'h00, 8'h00, "post_rst_rd"};
        apply_vec(v);
        check("final_tx_stable", stab_err, 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
